// File: rtl/io_port_arbiter.sv
// io_port_arbiter: round-robin arbiter giving a CPU bus and a UART monitor shared access to the LED port registers.
module io_port_arbiter #(
  parameter logic [7:0] PORT_A_INIT = 8'h00,
  parameter logic [2:0] LED_INIT    = 3'b000
) (
  input  logic       clk_48mhz,
  input  logic       reset,
  input  logic       req0,
  input  logic       req1,
  input  logic       we0,
  input  logic       we1,
  input  logic [1:0] addr0,
  input  logic [1:0] addr1,
  input  logic [7:0] wdata0,
  input  logic [7:0] wdata1,
  output logic       ack0,
  output logic       ack1,
  output logic [7:0] rdata,
  output logic [7:0] port_a,
  output logic       port_lr,
  output logic       port_lg,
  output logic       port_lb
);
  typedef enum logic [1:0] {IDLE, EXEC, ACK} state_t;
  state_t      state;
  logic        gnt;
  logic        last_grant;
  logic        we_q;
  logic [1:0]  addr_q;
  logic [7:0]  wdata_q;
  logic        busy;
  logic        pick;
  logic [7:0]  rd_mux;
  assign busy = state != IDLE;
  assign pick = (req0 & req1) ? ~last_grant : req1;
  always_comb begin
    rd_mux = addr_q == 2'd0 ? port_a :
             addr_q == 2'd1 ? {5'b0, port_lr, port_lg, port_lb} :
             addr_q == 2'd2 ? {6'b0, last_grant, busy} : 8'h5A;
  end
  // ack is set on the edge that leaves ACK, so it is high for the cycle after the ACK state
  always_ff @(posedge clk_48mhz or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      gnt        <= 1'b0;
      last_grant <= 1'b1;
      we_q       <= 1'b0;
      addr_q     <= 2'd0;
      wdata_q    <= 8'h00;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      rdata      <= 8'h00;
      port_a     <= PORT_A_INIT;
      {port_lr, port_lg, port_lb} <= LED_INIT;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        IDLE: if (req0 | req1) begin
          state   <= EXEC;
          gnt     <= pick;
          we_q    <= pick ? we1 : we0;
          addr_q  <= pick ? addr1 : addr0;
          wdata_q <= pick ? wdata1 : wdata0;
        end
        EXEC: begin
          state <= ACK;
          rdata <= rd_mux;
          if (we_q && addr_q == 2'd0) port_a <= wdata_q;
          if (we_q && addr_q == 2'd1) {port_lr, port_lg, port_lb} <= wdata_q[2:0];
        end
        ACK: begin
          state      <= IDLE;
          ack0       <= ~gnt;
          ack1       <= gnt;
          last_grant <= gnt;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_io_port_arbiter.sv
// tb_io_port_arbiter: directed self-checking bench for io_port_arbiter.
module tb_io_port_arbiter;
  logic       clk = 0;
  logic       reset = 1;
  logic       req0 = 0, req1 = 0, we0 = 0, we1 = 0;
  logic [1:0] addr0 = 0, addr1 = 0;
  logic [7:0] wdata0 = 0, wdata1 = 0;
  logic       ack0, ack1, port_lr, port_lg, port_lb;
  logic [7:0] rdata, port_a;
  int checks = 0;
  int errors = 0;

  always #10 clk = ~clk;

  io_port_arbiter #(.PORT_A_INIT(8'h81), .LED_INIT(3'b010)) dut (
    .clk_48mhz(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .port_a(port_a),
    .port_lr(port_lr), .port_lg(port_lg), .port_lb(port_lb)
  );

  // Issues one transaction and returns #1 after the edge where ack should be high.
  // Inputs are scrambled right after the grant so a missing latch shows up.
  task automatic txn(input bit n, input bit we, input logic [1:0] a, input logic [7:0] d);
    if (n) begin req1 = 1; we1 = we; addr1 = a; wdata1 = d; end
    else   begin req0 = 1; we0 = we; addr0 = a; wdata0 = d; end
    @(posedge clk); #1;
    req0 = 0; req1 = 0;
    if (n) begin wdata1 = ~d; addr1 = a ^ 2'b01; we1 = ~we; end
    else   begin wdata0 = ~d; addr0 = a ^ 2'b01; we0 = ~we; end
    @(posedge clk);
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    #25;
    checks++; if ({ack0, ack1} !== 2'b00) begin errors++; $display("FAIL reset_ack got %b want 00", {ack0, ack1}); end
    checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata got %h want 00", rdata); end
    checks++; if (port_a !== 8'h81) begin errors++; $display("FAIL reset_port_a got %h want 81", port_a); end
    checks++; if ({port_lr, port_lg, port_lb} !== 3'b010) begin errors++; $display("FAIL reset_led got %b want 010", {port_lr, port_lg, port_lb}); end
    @(negedge clk); reset = 0;
    @(negedge clk);
    txn(0, 0, 2'd2, 8'h00);
    checks++; if (ack0 !== 1'b1) begin errors++; $display("FAIL status_ack0 got %b want 1", ack0); end
    checks++; if (rdata !== 8'h03) begin errors++; $display("FAIL status_rdata got %h want 03", rdata); end
    @(negedge clk);
  endtask

  task automatic test_write_a;
    req0 = 1; we0 = 1; addr0 = 2'd0; wdata0 = 8'hA5;
    @(posedge clk); #1;
    req0 = 0; wdata0 = 8'h00;
    checks++; if (port_a !== 8'h81) begin errors++; $display("FAIL wr_k_port_a got %h want 81", port_a); end
    @(posedge clk); #1;
    checks++; if (port_a !== 8'hA5) begin errors++; $display("FAIL wr_k1_port_a got %h want a5", port_a); end
    checks++; if ({ack0, ack1} !== 2'b00) begin errors++; $display("FAIL wr_k1_ack got %b want 00", {ack0, ack1}); end
    @(posedge clk); #1;
    checks++; if ({ack0, ack1} !== 2'b10) begin errors++; $display("FAIL wr_k2_ack got %b want 10", {ack0, ack1}); end
    @(posedge clk); #1;
    checks++; if ({ack0, ack1} !== 2'b00) begin errors++; $display("FAIL wr_k3_ack got %b want 00", {ack0, ack1}); end
    @(negedge clk);
  endtask

  task automatic test_led;
    txn(1, 1, 2'd1, 8'hFF);
    checks++; if ({ack0, ack1} !== 2'b01) begin errors++; $display("FAIL led_wr_ack got %b want 01", {ack0, ack1}); end
    checks++; if ({port_lr, port_lg, port_lb} !== 3'b111) begin errors++; $display("FAIL led_value got %b want 111", {port_lr, port_lg, port_lb}); end
    @(negedge clk);
    txn(1, 0, 2'd1, 8'h00);
    checks++; if (ack1 !== 1'b1) begin errors++; $display("FAIL led_rd_ack1 got %b want 1", ack1); end
    checks++; if (rdata !== 8'h07) begin errors++; $display("FAIL led_rdata got %h want 07", rdata); end
    @(negedge clk);
  endtask

  task automatic test_id;
    txn(0, 1, 2'd3, 8'h00);
    checks++; if (ack0 !== 1'b1) begin errors++; $display("FAIL id_wr_ack0 got %b want 1", ack0); end
    checks++; if (port_a !== 8'hA5) begin errors++; $display("FAIL id_wr_port_a got %h want a5", port_a); end
    checks++; if ({port_lr, port_lg, port_lb} !== 3'b111) begin errors++; $display("FAIL id_wr_led got %b want 111", {port_lr, port_lg, port_lb}); end
    @(negedge clk);
    txn(0, 0, 2'd3, 8'h00);
    checks++; if (rdata !== 8'h5A) begin errors++; $display("FAIL id_rdata got %h want 5a", rdata); end
    @(negedge clk);
  endtask

  task automatic test_drop;
    int acks = 0;
    req0 = 1; we0 = 1; addr0 = 2'd0; wdata0 = 8'h66;
    @(posedge clk); #1;
    @(posedge clk); #1;
    req0 = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (ack0) acks++;
    end
    checks++; if (acks !== 1) begin errors++; $display("FAIL drop_ack_count got %0d want 1", acks); end
    checks++; if (port_a !== 8'h66) begin errors++; $display("FAIL drop_port_a got %h want 66", port_a); end
    @(negedge clk);
  endtask

  task automatic test_reset_exec;
    int acks = 0;
    req0 = 1; we0 = 1; addr0 = 2'd0; wdata0 = 8'h3C;
    @(posedge clk); #2;
    req0 = 0; reset = 1;
    #1;
    checks++; if (port_a !== 8'h81) begin errors++; $display("FAIL rst_exec_port_a got %h want 81", port_a); end
    checks++; if ({port_lr, port_lg, port_lb} !== 3'b010) begin errors++; $display("FAIL rst_exec_led got %b want 010", {port_lr, port_lg, port_lb}); end
    @(negedge clk); reset = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (ack0 | ack1) acks++;
    end
    checks++; if (acks !== 0) begin errors++; $display("FAIL rst_exec_acks got %0d want 0", acks); end
    checks++; if (port_a !== 8'h81) begin errors++; $display("FAIL rst_exec_port_a_after got %h want 81", port_a); end
    @(negedge clk);
  endtask

  task automatic test_contention;
    int ids[3] = '{-1, -1, -1};
    int cyc[3] = '{-1, -1, -1};
    int n = 0;
    req0 = 1; we0 = 0; addr0 = 2'd3;
    req1 = 1; we1 = 0; addr1 = 2'd3;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if ((ack0 | ack1) && n < 3) begin ids[n] = ack1 ? 1 : 0; cyc[n] = c; n++; end
    end
    req0 = 0; req1 = 0;
    checks++; if (ids[0] !== 0) begin errors++; $display("FAIL rr_first_id got %0d want 0", ids[0]); end
    checks++; if (ids[1] !== 1) begin errors++; $display("FAIL rr_second_id got %0d want 1", ids[1]); end
    checks++; if (ids[2] !== 0) begin errors++; $display("FAIL rr_third_id got %0d want 0", ids[2]); end
    checks++; if (cyc[0] !== 3) begin errors++; $display("FAIL rr_first_cycle got %0d want 3", cyc[0]); end
    checks++; if (cyc[1] !== 6) begin errors++; $display("FAIL rr_second_cycle got %0d want 6", cyc[1]); end
    checks++; if (cyc[2] !== 9) begin errors++; $display("FAIL rr_third_cycle got %0d want 9", cyc[2]); end
    checks++; if (rdata !== 8'h5A) begin errors++; $display("FAIL rr_rdata got %h want 5a", rdata); end
    @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_write_a;
    test_led;
    test_id;
    test_drop;
    test_reset_exec;
    test_contention;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/io_port_arbiter.md
IO_PORT_ARBITER -- requirements
Module: io_port_arbiter

Interface
REQ-001 SHALL have parameter PORT_A_INIT, default 8'h00, meaning the reset value of port_a.
REQ-002 SHALL have parameter LED_INIT, default 3'b000, meaning the reset value of {port_lr,port_lg,port_lb}.
REQ-003 SHALL have port clk_48mhz  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have, for n in {0,1}, port reqN  input  1  requester n transaction request (0 = CPU bus, 1 = UART debug monitor).
REQ-006 SHALL have, for n in {0,1}, port weN  input  1  1 = write, 0 = read.
REQ-007 SHALL have, for n in {0,1}, port addrN  input  2  register select.
REQ-008 SHALL have, for n in {0,1}, port wdataN  input  8  write data.
REQ-009 SHALL have, for n in {0,1}, port ackN  output  1  one-cycle completion strobe to requester n.
REQ-010 SHALL have port rdata  output  8  read data; valid in the cycle ackN is high.
REQ-011 SHALL have port port_a  output  8  registered LED-bar drive, positive logic.
REQ-012 SHALL have ports port_lr, port_lg, port_lb  output  1 each  registered RGB drive, positive logic.

Function
REQ-013 SHALL decode the register map as: addr 0 = port_a (R/W); addr 1 = {5'b0,lr,lg,lb} (R/W, wdata[7:3] ignored); addr 2 = status {6'b0,last_grant,busy} (RO); addr 3 = 8'h5A ID (RO).
REQ-014 SHALL implement FSM states IDLE, EXEC, ACK; IDLE->EXEC when req0|req1; EXEC->ACK unconditionally; ACK->IDLE unconditionally.
REQ-015 SHALL, in IDLE with both requests high, grant the requester not equal to last_grant (round-robin).
REQ-016 SHALL, in IDLE with one request high, grant that requester regardless of last_grant.
REQ-017 SHALL latch grant id, we, addr and wdata of the winner on the IDLE->EXEC edge; later changes to those inputs do not affect the transaction.
REQ-018 SHALL, in EXEC, perform the write to the addressed register and capture read data into rdata.
REQ-019 SHALL, in ACK, assert ack of the granted requester only, for exactly one cycle, and set last_grant to the granted id.
REQ-020 SHALL ignore writes to addr 2 and 3 without side effects, still completing with ack.
REQ-021 SHALL return current register contents for reads, with no register change.
REQ-022 SHALL give latency: req sampled high in IDLE at edge k -> register updated at edge k+1 -> ack high from edge k+2 to edge k+3; next grant no earlier than edge k+3.
REQ-023 SHALL define busy = 1 in EXEC and ACK, 0 in IDLE.
REQ-024 SHALL hold rdata stable from ACK until the next EXEC.
REQ-025 SHALL complete a granted transaction even if its req is deasserted before ack.
REQ-026 SHALL start a new transaction if the requester holds req high after its ack, with no extra idle cycle beyond the ACK->IDLE transition.
REQ-027 SHALL not change any output combinationally from request inputs; all outputs are registered.

Reset
REQ-028 SHALL, while reset is high, force state IDLE, ack0 = ack1 = 0, rdata = 8'h00, port_a = PORT_A_INIT, {lr,lg,lb} = LED_INIT, and last_grant = 1 so requester 0 wins the first contention.
REQ-029 SHALL abort any in-flight transaction on reset assertion; no ack is issued for it after reset releases.
REQ-030 SHALL take effect asynchronously on assertion; the FSM leaves IDLE no earlier than the first rising edge after reset deasserts.

Verification
REQ-031 SHALL cover: req0 write addr0 = 8'hA5 alone -> port_a = 8'hA5 at edge k+1, ack0 pulse at edge k+2, ack1 never high.
REQ-032 SHALL cover: req0 and req1 asserted together from reset, both holding -> ack0 first, then ack1, then ack0 (strict alternation).
REQ-033 SHALL cover: req1 write addr1 = 8'hFF then read addr1 -> port_lr = port_lg = port_lb = 1, rdata = 8'h07 with ack1.
REQ-034 SHALL cover: write addr3 = 8'h00 then read addr3 -> ack issued, rdata = 8'h5A, port_a and LEDs unchanged.
REQ-035 SHALL cover: reset asserted in EXEC of a write addr0 = 8'h3C -> port_a = PORT_A_INIT, no ack, first post-reset contention granted to requester 0.
REQ-036 SHALL cover: req0 dropped one cycle after grant -> write still applied and ack0 pulses once.
